sprite_cfg_ctrl: RTL and testbench
==================================

Name: sprite_cfg_ctrl

Overview:
- Frame-synchronous configuration controller for the sprite engine: owns the per-blob settings array (enable, position, size, RAM address, layer) that feeds the gpu top level.
- Software writes a shadow bank through a valid/ready register port, then requests a commit.
- The shadow bank is copied to the active bank in one cycle at the next vertical-sync assertion, so settings never change mid-frame (no tearing).
- Sits between the CPU/AXI register slave and the gpu blob inputs.

Parameters:
- NR_OF_BLOBS, 4, number of blobs; power of two, 2..16
- ram_add_width, 8, width of blob RAM start address
- BLOB_IDX_W, 2, width of cfg_blob; equals log2(NR_OF_BLOBS)
- VS_POL, 0, active level of v_sync (0 = active-low)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cfg_valid  in  1  register write request
- cfg_ready  out  1  write accepted when cfg_valid && cfg_ready
- cfg_blob  in  BLOB_IDX_W  target blob index
- cfg_field  in  3  0 enable, 1 y1_pos, 2 x1_pos, 3 height, 4 width, 5 ram_address, 6 layer, 7 reserved
- cfg_data  in  16  write data, LSB-aligned
- commit_req  in  1  single-cycle commit request
- v_sync  in  1  vertical sync from sync_mod (undelayed)
- commit_pending  out  1  high while a commit waits for v_sync
- commit_done  out  1  one-cycle pulse when the active bank is updated
- sprite_enable  out  1 x NR_OF_BLOBS  active enable array
- y1_pos, x1_pos, height, width  out  10 x NR_OF_BLOBS  active geometry arrays
- ram_address  out  ram_add_width x NR_OF_BLOBS  active RAM start array
- layer  out  2 x NR_OF_BLOBS  active layer array

Behaviour:
- Reset (async): all shadow and active fields 0, FSM = IDLE, commit_pending 0, commit_done 0, v_sync history register = inactive level. cfg_ready reads 1 while in reset-released IDLE.
- Width rules: each field takes the low bits of cfg_data (enable = bit 0, layer = bits 1:0, geometry = bits 9:0, address = bits ram_add_width-1:0). Upper bits are ignored. Field 7 is accepted and discarded.
- Edge detect: v_sync is registered once. vs_edge = (registered value inactive) && (current value == VS_POL).
- FSM:
  - IDLE: cfg_ready = 1. An accepted write updates the shadow bank on the same clock edge. commit_req -> ARMED. A write and commit_req in the same cycle: the write lands and is included in the commit.
  - ARMED: cfg_ready = 0 (shadow frozen), commit_pending = 1, commit_req ignored. vs_edge -> COPY.
  - COPY: one cycle. Active bank <= shadow bank for all blobs simultaneously. commit_done = 1 on the following cycle (registered). Next state IDLE.
- Latency: v_sync assertion at cycle N -> edge detected at N+1 -> COPY at N+1 -> active outputs change at N+2 -> commit_done high during N+2.
- Active outputs are registers and change only in COPY.
- vs_edge outside ARMED has no effect.
- Shadow is not cleared by a commit; a subsequent commit without writes reproduces the same values.
- cfg_valid while cfg_ready = 0: not accepted; the master must hold the request (standard valid/ready).
- Reset mid-ARMED or mid-COPY: everything returns to reset values; the pending commit is lost.
- Active outputs must remain glitch-free across COPY: all blobs update on the same edge.

Optional Feature:
- FRAME_CNT_EN defined: adds output frame_cnt [15:0], reset 0, incremented on every vs_edge regardless of state, wraps 0xFFFF -> 0. Adds output commit_frame [15:0], which latches frame_cnt's post-increment value in COPY.
- FRAME_CNT_EN undefined: neither port exists and no counter logic is built. All other behaviour is identical.

Test Plan:
- Reset, then write blob 2 x1_pos = 0x1F3, commit_req, toggle v_sync low (VS_POL = 0) -> x1_pos[2] = 0x1F3 two cycles after the edge, commit_done pulses exactly once, and other blobs stay 0.
- Write cfg_data = 0xFFFF to layer of blob 1 and to ram_address of blob 0 -> after commit, layer[1] = 3 and ram_address[0] = 0xFF (low bits only).
- In ARMED, assert cfg_valid writing height = 0x050 -> cfg_ready = 0 with no acceptance. The write is accepted only after COPY, and active height is unchanged until the next commit.
- Same-cycle cfg write (blob 3 enable = 1) and commit_req -> after the next v_sync edge, sprite_enable[3] = 1.
- Commit armed, async reset asserted mid-ARMED, then v_sync edge -> no commit_done, all outputs 0, commit_pending 0.
- FRAME_CNT_EN defined: 3 v_sync frames with a commit armed in frame 2 -> frame_cnt = 3 and commit_frame = 2. Preload frame_cnt to 0xFFFF (force), then one more edge -> frame_cnt = 0.

Source files
------------

// File: rtl/sprite_cfg_ctrl_if.sv
// Register-write and commit handshake between the CPU register slave and
// the sprite configuration controller.
interface sprite_cfg_ctrl_if #(
  parameter int BLOB_IDX_W = 2
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [BLOB_IDX_W-1:0] cfg_blob;
  logic [2:0]            cfg_field;
  logic [15:0]           cfg_data;
  logic                  commit_req;
  logic                  commit_pending;
  logic                  commit_done;

  modport master (
    output cfg_valid, cfg_blob, cfg_field, cfg_data, commit_req,
    input  cfg_ready, commit_pending, commit_done
  );

  modport slave (
    input  cfg_valid, cfg_blob, cfg_field, cfg_data, commit_req,
    output cfg_ready, commit_pending, commit_done
  );
endinterface

// File: rtl/sprite_cfg_ctrl.sv
// Double-buffered per-blob sprite settings; shadow bank is copied to the
// active bank at the first v_sync edge after a commit. Optional FRAME_CNT_EN
// adds a free-running frame counter and the frame number of the last commit.

// One blob's shadow/active register pair.
module sprite_blob_slot #(
  parameter int ram_add_width = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [2:0]               field,
  input  logic [15:0]              data,
  input  logic                     copy,
  output logic                     sprite_enable,
  output logic [9:0]               y1_pos,
  output logic [9:0]               x1_pos,
  output logic [9:0]               height,
  output logic [9:0]               width,
  output logic [ram_add_width-1:0] ram_address,
  output logic [1:0]               layer
);
  typedef struct packed {
    logic                     en;
    logic [9:0]               y1;
    logic [9:0]               x1;
    logic [9:0]               h;
    logic [9:0]               w;
    logic [ram_add_width-1:0] ram;
    logic [1:0]               layer;
  } blob_cfg_t;

  blob_cfg_t sh, act;

  // Only the low bits of data are architecturally meaningful per field.
  logic unused_data;
  assign unused_data = ^data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh <= '0;
    end else if (wr_en) begin
      case (field)
        3'd0: sh.en    <= data[0];
        3'd1: sh.y1    <= data[9:0];
        3'd2: sh.x1    <= data[9:0];
        3'd3: sh.h     <= data[9:0];
        3'd4: sh.w     <= data[9:0];
        3'd5: sh.ram   <= data[ram_add_width-1:0];
        3'd6: sh.layer <= data[1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     act <= '0;
    else if (copy) act <= sh;
  end

  assign sprite_enable = act.en;
  assign y1_pos        = act.y1;
  assign x1_pos        = act.x1;
  assign height        = act.h;
  assign width         = act.w;
  assign ram_address   = act.ram;
  assign layer         = act.layer;
endmodule

module sprite_cfg_ctrl #(
  parameter int NR_OF_BLOBS   = 4,
  parameter int ram_add_width = 8,
  parameter int BLOB_IDX_W    = 2,
  parameter bit VS_POL        = 1'b0
) (
  input  logic                                       clk,
  input  logic                                       reset,
  sprite_cfg_ctrl_if.slave                           cfg,
  input  logic                                       v_sync,
  output logic [NR_OF_BLOBS-1:0]                     sprite_enable,
  output logic [NR_OF_BLOBS-1:0][9:0]                y1_pos,
  output logic [NR_OF_BLOBS-1:0][9:0]                x1_pos,
  output logic [NR_OF_BLOBS-1:0][9:0]                height,
  output logic [NR_OF_BLOBS-1:0][9:0]                width,
  output logic [NR_OF_BLOBS-1:0][ram_add_width-1:0]  ram_address,
  output logic [NR_OF_BLOBS-1:0][1:0]                layer
`ifdef FRAME_CNT_EN
  ,
  output logic [15:0]                                frame_cnt,
  output logic [15:0]                                commit_frame
`endif
);
  typedef enum logic [1:0] {IDLE, ARMED, COPY} state_t;

  state_t state, state_nxt;
  logic   vs_q, vs_edge, wr, copy, done_q;

  // History starts at the inactive level so a sync already active out of
  // reset is not mistaken for a fresh edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vs_q <= ~VS_POL;
    else       vs_q <= v_sync;
  end
  assign vs_edge = (vs_q != VS_POL) && (v_sync == VS_POL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= copy;
    end
  end

  always_comb begin
    state_nxt          = state;
    copy               = 1'b0;
    cfg.cfg_ready      = 1'b0;
    cfg.commit_pending = 1'b0;
    case (state)
      IDLE: begin
        cfg.cfg_ready = 1'b1;
        if (cfg.commit_req) state_nxt = ARMED;
      end
      ARMED: begin
        cfg.commit_pending = 1'b1;
        if (vs_edge) state_nxt = COPY;
      end
      COPY: begin
        copy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cfg.commit_done = done_q;
  assign wr              = cfg.cfg_valid && cfg.cfg_ready;

  for (genvar i = 0; i < NR_OF_BLOBS; i++) begin : g_blob
    sprite_blob_slot #(.ram_add_width(ram_add_width)) u_slot (
      .clk           (clk),
      .reset         (reset),
      .wr_en         (wr && (cfg.cfg_blob == BLOB_IDX_W'(i))),
      .field         (cfg.cfg_field),
      .data          (cfg.cfg_data),
      .copy          (copy),
      .sprite_enable (sprite_enable[i]),
      .y1_pos        (y1_pos[i]),
      .x1_pos        (x1_pos[i]),
      .height        (height[i]),
      .width         (width[i]),
      .ram_address   (ram_address[i]),
      .layer         (layer[i])
    );
  end

`ifdef FRAME_CNT_EN
  // COPY follows the edge by one cycle, so frame_cnt already holds the
  // post-increment value when it is captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt    <= '0;
      commit_frame <= '0;
    end else begin
      if (vs_edge) frame_cnt    <= frame_cnt + 16'd1;
      if (copy)    commit_frame <= frame_cnt;
    end
  end
`endif
endmodule

// File: tb/tb_sprite_cfg_ctrl.sv
// Self-checking bench for sprite_cfg_ctrl: table vectors, hand sequences for
// hold/reset corners, and random rounds against a shadow/active array model.
module tb_sprite_cfg_ctrl;
  localparam int NB  = 4;
  localparam int RAW = 8;
  localparam int BIW = 2;
  localparam bit VSP = 1'b0;

  logic clk = 1'b0, reset = 1'b1, v_sync = ~VSP;
  logic [NB-1:0]          sprite_enable;
  logic [NB-1:0][9:0]     y1_pos, x1_pos, height, width;
  logic [NB-1:0][RAW-1:0] ram_address;
  logic [NB-1:0][1:0]     layer;
`ifdef FRAME_CNT_EN
  logic [15:0] frame_cnt, commit_frame;
`endif

  sprite_cfg_ctrl_if #(.BLOB_IDX_W(BIW)) cfg ();

  sprite_cfg_ctrl #(.NR_OF_BLOBS(NB), .ram_add_width(RAW), .BLOB_IDX_W(BIW), .VS_POL(VSP)) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg           (cfg),
    .v_sync        (v_sync),
    .sprite_enable (sprite_enable),
    .y1_pos        (y1_pos),
    .x1_pos        (x1_pos),
    .height        (height),
    .width         (width),
    .ram_address   (ram_address),
    .layer         (layer)
`ifdef FRAME_CNT_EN
    ,
    .frame_cnt     (frame_cnt),
    .commit_frame  (commit_frame)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, done_cnt = 0;
  int sh[NB][8], act[NB][8];

  always @(negedge clk) if (cfg.commit_done === 1'b1) done_cnt++;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int msk(input int f, input int d);
    case (f)
      0:       return d & 1;
      1,2,3,4: return d & 'h3FF;
      5:       return d & 'hFF;
      6:       return d & 3;
      default: return 0;
    endcase
  endfunction

  function automatic int dut_val(input int b, input int f);
    case (f)
      0: return int'(sprite_enable[b]);
      1: return int'(y1_pos[b]);
      2: return int'(x1_pos[b]);
      3: return int'(height[b]);
      4: return int'(width[b]);
      5: return int'(ram_address[b]);
      6: return int'(layer[b]);
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++)
      for (int f = 0; f < 8; f++) begin sh[b][f] = 0; act[b][f] = 0; end
  endtask

  task automatic model_commit();
    for (int b = 0; b < NB; b++)
      for (int f = 0; f < 8; f++) act[b][f] = sh[b][f];
  endtask

  task automatic check_all(input string name);
    for (int b = 0; b < NB; b++)
      for (int f = 0; f < 7; f++)
        check($sformatf("%s b%0d f%0d", name, b, f), dut_val(b, f), act[b][f]);
  endtask

  task automatic do_write(input int b, input int f, input int d, input bit with_commit);
    int n = 0;
    @(negedge clk);
    cfg.cfg_valid  = 1'b1;
    cfg.cfg_blob   = BIW'(b);
    cfg.cfg_field  = 3'(f);
    cfg.cfg_data   = 16'(d);
    cfg.commit_req = with_commit;
    while (cfg.cfg_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("write_timeout", 0, 1);
    @(negedge clk);
    cfg.cfg_valid  = 1'b0;
    cfg.commit_req = 1'b0;
    if (f != 7) sh[b][f] = msk(f, d);
  endtask

  task automatic do_commit();
    @(negedge clk);
    cfg.commit_req = 1'b1;
    @(negedge clk);
    cfg.commit_req = 1'b0;
  endtask

  // Drive v_sync active for 4 cycles; lat = negedges until commit_done, -1 if none.
  task automatic vs_pulse(output int lat);
    lat = -1;
    @(negedge clk);
    v_sync = VSP;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (cfg.commit_done === 1'b1 && lat < 0) lat = i;
      if (i == 4) v_sync = ~VSP;
    end
  endtask

  typedef struct { int b; int f; int d; int exp; } vec_t;
  vec_t vt[8];

  initial begin
    int lat, c0;
    cfg.cfg_valid = 0; cfg.cfg_blob = '0; cfg.cfg_field = '0; cfg.cfg_data = '0; cfg.commit_req = 0;
    vt[0] = '{1, 6, 'hFFFF, 3};
    vt[1] = '{0, 5, 'hFFFF, 'hFF};
    vt[2] = '{3, 0, 'hFFFE, 0};
    vt[3] = '{0, 0, 'hFFFF, 1};
    vt[4] = '{1, 1, 'hFC00, 0};
    vt[5] = '{3, 4, 'h03FF, 'h3FF};
    vt[6] = '{2, 3, 'h1234, 'h234};
    vt[7] = '{2, 1, 'h8155, 'h155};
    model_reset();

    repeat (2) @(negedge clk);
    check("reset_ready", int'(cfg.cfg_ready), 1);
    reset = 1'b0;
    @(negedge clk);
    check("reset_pending", int'(cfg.commit_pending), 0);
    check("reset_done", int'(cfg.commit_done), 0);
    check_all("reset");

`ifdef FRAME_CNT_EN
    check("frame_reset", int'(frame_cnt), 0);
    vs_pulse(lat);
    do_commit();
    vs_pulse(lat);
    vs_pulse(lat);
    check("frame_cnt3", int'(frame_cnt), 3);
    check("commit_frame2", int'(commit_frame), 2);
    @(negedge clk);
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    vs_pulse(lat);
    check("frame_wrap", int'(frame_cnt), 0);
`endif

    // Basic commit: exact latency, single done pulse, neighbours untouched.
    do_write(2, 2, 'h1F3, 1'b0);
    do_commit();
    check("armed_pending", int'(cfg.commit_pending), 1);
    check("armed_ready", int'(cfg.cfg_ready), 0);
    check("armed_no_change", int'(x1_pos[2]), 0);
    c0 = done_cnt;
    vs_pulse(lat);
    model_commit();
    check("x1_latency", lat, 2);
    check("done_once", done_cnt - c0, 1);
    check("idle_pending", int'(cfg.commit_pending), 0);
    check_all("x1_commit");

    // Field-by-field table: write, commit, check the masked value.
    foreach (vt[k]) begin
      do_write(vt[k].b, vt[k].f, vt[k].d, 1'b0);
      do_commit();
      vs_pulse(lat);
      model_commit();
      check($sformatf("vec%0d_lat", k), lat, 2);
      check($sformatf("vec%0d_val", k), dut_val(vt[k].b, vt[k].f), vt[k].exp);
    end

    // Reserved field is accepted and discarded.
    do_write(1, 7, 'hFFFF, 1'b0);
    do_commit();
    vs_pulse(lat);
    check_all("field7");

    // Write held during ARMED lands only after COPY and needs a second commit.
    do_commit();
    @(negedge clk);
    cfg.cfg_valid = 1'b1; cfg.cfg_blob = 2'd0; cfg.cfg_field = 3'd3; cfg.cfg_data = 16'h0050;
    repeat (3) @(negedge clk);
    check("held_ready", int'(cfg.cfg_ready), 0);
    check("held_pending", int'(cfg.commit_pending), 1);
    check("held_shadow_frozen", int'(dut.g_blob[0].u_slot.sh.h), sh[0][3]);
    vs_pulse(lat);
    cfg.cfg_valid = 1'b0;
    check("held_lat", lat, 2);
    check("held_height_unchanged", int'(height[0]), act[0][3]);
    sh[0][3] = 'h50;
    do_commit();
    vs_pulse(lat);
    model_commit();
    check_all("held_commit");

    // Shadow survives a commit: recommit with no writes is a no-op.
    do_commit();
    vs_pulse(lat);
    check("recommit_lat", lat, 2);
    check_all("recommit");

    // Same-cycle write and commit.
    do_write(3, 0, 1, 1'b1);
    check("same_cycle_pending", int'(cfg.commit_pending), 1);
    vs_pulse(lat);
    model_commit();
    check("same_cycle_en", int'(sprite_enable[3]), 1);

    // v_sync with nothing armed does nothing.
    do_write(2, 4, 'h2AA, 1'b0);
    c0 = done_cnt;
    vs_pulse(lat);
    check("idle_vs_done", done_cnt - c0, 0);
    check_all("idle_vs");

    // Reset while ARMED drops the commit and clears everything.
    do_write(1, 1, 'h155, 1'b0);
    do_commit();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_armed_pending", int'(cfg.commit_pending), 0);
    reset = 1'b0;
    model_reset();
    c0 = done_cnt;
    vs_pulse(lat);
    check("rst_armed_done", done_cnt - c0, 0);
    check("rst_armed_pending2", int'(cfg.commit_pending), 0);
    check_all("rst_armed");

    // Random rounds against the array model.
    for (int r = 0; r < 30; r++) begin
      int nw = $urandom_range(1, 5);
      bool_blk: begin
        bit comb = $urandom_range(0, 1);
        for (int w = 0; w < nw; w++)
          do_write($urandom_range(0, NB-1), $urandom_range(0, 7), $urandom_range(0, 'hFFFF),
                   comb && (w == nw - 1));
        if (!comb) do_commit();
      end
      c0 = done_cnt;
      vs_pulse(lat);
      model_commit();
      check($sformatf("rnd%0d_lat", r), lat, 2);
      check($sformatf("rnd%0d_done", r), done_cnt - c0, 1);
      check_all($sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
